axis_pattern_gen: RTL

AXI-stream video test-pattern transmitter for the image-processing pipeline. Generates raster frames of `p_img_width` × `p_img_height` pixels with start-of-frame and end-of-line sideband. It drives the input side of a stream FIFO or filter stage and honours backpressure per AXI-stream rules. It is the stimulus source for on-board bring-up and for the filter regression benches.

---
 rtl/axis_pattern_gen_if.sv | 27 ++
 rtl/axis_pattern_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_pattern_gen_if.sv
// axis_pattern_gen_if: AXI-stream video bundle (data, valid, ready, sof/tuser, eol/tlast).
// master drives data/valid/sof/eol and samples ready; slave is the reverse.
interface axis_pattern_gen_if #(
  parameter int p_width = 8
) ();
  logic [p_width-1:0] o_data_out;
  logic               o_valid_out;
  logic               i_ready_out;
  logic               o_sof;
  logic               o_eol;

  modport master (
    output o_data_out,
    output o_valid_out,
    output o_sof,
    output o_eol,
    input  i_ready_out
  );

  modport slave (
    input  o_data_out,
    input  o_valid_out,
    input  o_sof,
    input  o_eol,
    output i_ready_out
  );
endinterface

// File: rtl/axis_pattern_gen.sv
// axis_pattern_gen: raster test-pattern source over AXI-stream (ramp/checker/index).
// Ports: i_clk, i_reset_n (async low), i_start, i_continuous, i_pattern, m_axis (master),
// o_busy, o_frame_done, o_frame_count, o_stall_count.
// Option: AXIS_PATTERN_GEN_STALL_CNT_EN enables the saturating backpressure counter.
module axis_pattern_gen #(
  parameter int p_width        = 8,
  parameter int p_img_width    = 640,
  parameter int p_img_height   = 480,
  parameter int p_frame_gap    = 16,
  parameter int p_checker_log2 = 3
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_start,
  input  logic                i_continuous,
  input  logic [1:0]          i_pattern,
  axis_pattern_gen_if.master  m_axis,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic [15:0]         o_frame_count,
  output logic [31:0]         o_stall_count
);

  localparam int XW = (p_img_width > 1) ? $clog2(p_img_width) : 1;
  localparam int YW = (p_img_height > 1) ? $clog2(p_img_height) : 1;
  localparam int GW = (p_frame_gap > 0) ? $clog2(p_frame_gap + 1) : 1;
  localparam logic [XW-1:0] LP_X_LAST = XW'(p_img_width - 1);
  localparam logic [YW-1:0] LP_Y_LAST = YW'(p_img_height - 1);
  localparam logic [GW-1:0] LP_G_LAST = GW'(p_frame_gap - 1);
  localparam bit LP_HAS_GAP = (p_frame_gap > 0);

  typedef enum logic [1:0] {
    s_idle,
    s_active,
    s_gap
  } state_t;

  state_t             r_state, w_state;
  logic [XW-1:0]      r_x, w_x;
  logic [YW-1:0]      r_y, w_y;
  logic [GW-1:0]      r_gap, w_gap;
  logic [1:0]         r_pat, w_pat;
  logic [p_width-1:0] r_data, w_data;
  logic               r_valid, w_valid;
  logic               r_sof, w_sof;
  logic               r_eol, w_eol;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic [15:0]        r_fcnt;
  logic               w_hs;
  logic               w_last;

  function automatic logic [p_width-1:0] f_pix(
    input logic [1:0]    pat,
    input logic [XW-1:0] x,
    input logic [YW-1:0] y
  );
    logic [31:0] xe;
    logic [31:0] ye;
    logic [31:0] v;
    xe = 32'(x);
    ye = 32'(y);
    v  = '0;
    unique case (pat)
      2'd0: v = xe;
      2'd1: v = ye;
      2'd2: return {p_width{xe[p_checker_log2] ^ ye[p_checker_log2]}};
      default: v = ye * 32'(p_img_width) + xe;
    endcase
    return p_width'(v);
  endfunction

  assign w_hs   = r_valid & m_axis.i_ready_out;
  assign w_last = (r_x == LP_X_LAST) & (r_y == LP_Y_LAST);

  always_comb begin
    w_state = r_state;
    w_x     = r_x;
    w_y     = r_y;
    w_gap   = r_gap;
    w_pat   = r_pat;
    w_data  = r_data;
    w_valid = r_valid;
    w_sof   = r_sof;
    w_eol   = r_eol;
    w_busy  = r_busy;
    w_done  = 1'b0;
    unique case (r_state)
      s_idle: begin
        if (i_start) begin
          w_state = s_active;
          w_pat   = i_pattern;
          w_x     = '0;
          w_y     = '0;
          w_data  = f_pix(i_pattern, '0, '0);
          w_valid = 1'b1;
          w_sof   = 1'b1;
          w_eol   = 1'b0;
          w_busy  = 1'b1;
        end
      end
      s_active: begin
        if (w_hs && w_last) begin
          w_done  = 1'b1;
          w_x     = '0;
          w_y     = '0;
          w_sof   = 1'b0;
          w_eol   = 1'b0;
          w_valid = 1'b0;
          w_data  = '0;
          if (i_continuous && LP_HAS_GAP) begin
            w_state = s_gap;
            w_gap   = '0;
          end else if (i_continuous) begin
            // zero gap: next frame's first pixel follows back-to-back
            w_pat   = i_pattern;
            w_data  = f_pix(i_pattern, '0, '0);
            w_valid = 1'b1;
            w_sof   = 1'b1;
          end else begin
            w_state = s_idle;
            w_busy  = 1'b0;
          end
        end else if (w_hs) begin
          if (r_x == LP_X_LAST) begin
            w_x = '0;
            w_y = r_y + YW'(1);
          end else begin
            w_x = r_x + XW'(1);
          end
          w_data = f_pix(r_pat, w_x, w_y);
          w_sof  = 1'b0;
          w_eol  = (w_x == LP_X_LAST);
        end
      end
      s_gap: begin
        if (r_gap == LP_G_LAST) begin
          w_state = s_active;
          w_pat   = i_pattern;
          w_data  = f_pix(i_pattern, '0, '0);
          w_valid = 1'b1;
          w_sof   = 1'b1;
        end else begin
          w_gap = r_gap + GW'(1);
        end
      end
      default: w_state = s_idle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= s_idle;
      r_x     <= '0;
      r_y     <= '0;
      r_gap   <= '0;
      r_pat   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state;
      r_x     <= w_x;
      r_y     <= w_y;
      r_gap   <= w_gap;
      r_pat   <= w_pat;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_sof   <= w_sof;
      r_eol   <= w_eol;
      r_busy  <= w_busy;
      r_done  <= w_done;
      if (w_done) r_fcnt <= r_fcnt + 16'd1;
    end
  end

`ifdef AXIS_PATTERN_GEN_STALL_CNT_EN
  logic [31:0] r_stall;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stall <= '0;
    end else if (r_valid && !m_axis.i_ready_out && (r_stall != '1)) begin
      r_stall <= r_stall + 32'd1;
    end
  end
  assign o_stall_count = r_stall;
`else
  assign o_stall_count = '0;
`endif

  assign m_axis.o_data_out  = r_data;
  assign m_axis.o_valid_out = r_valid;
  assign m_axis.o_sof       = r_sof;
  assign m_axis.o_eol       = r_eol;
  assign o_busy             = r_busy;
  assign o_frame_done       = r_done;
  assign o_frame_count      = r_fcnt;

endmodule
